// File: rtl/inst_sram_axi_bridge_if.sv
// Signal bundle between the fetch-side SRAM request port and the AXI read-only
// master port of inst_sram_axi_bridge; master = bridge side, slave = environment.
interface inst_sram_axi_bridge_if;
    logic        inst_sram_en;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        input  inst_sram_en, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output inst_sram_en, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_sram_axi_bridge.sv
// Instruction fetch bridge: turns each accepted SRAM-style fetch into a single-beat
// AXI read and returns the data in order, with up to MAX_OUTSTANDING reads in flight.
module inst_sram_axi_bridge #(
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [3:0] AXI_ID          = 4'd0
) (
    input logic                     clk,
    input logic                     resetn,
    inst_sram_axi_bridge_if.master  bus
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        IDLE,
        AR_WAIT
    } arState_e;

    arState_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arsize_q, arsize_d;
    logic        dataOk_q, dataOk_d;
    logic [31:0] rdata_q, rdata_d;

    logic addrHs;
    logic rReady;
    logic rHs;
    logic unused_rFields;

    // A new request may only be taken while no AR is pending, so arvalid stays registered.
    assign addrHs = bus.inst_sram_en & ~bus.inst_sram_wr & (state_q == IDLE)
                  & (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign rReady = (cnt_q != '0) & (bus.rid == AXI_ID);
    assign rHs    = bus.rvalid & rReady;

    assign unused_rFields = ^{bus.rresp, bus.rlast};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (addrHs) state_d = AR_WAIT;
            AR_WAIT: if (bus.arready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.arvalid           = (state_q == AR_WAIT);
        bus.inst_sram_addr_ok = addrHs;
        bus.rready            = rReady;
    end

    always_comb begin
        araddr_d = araddr_q;
        arsize_d = arsize_q;
        if (addrHs) begin
            araddr_d = bus.inst_sram_addr;
            arsize_d = {1'b0, bus.inst_sram_size};
        end
    end

    // Simultaneous accept and return leave the in-flight count unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({addrHs, rHs})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        dataOk_d = rHs;
        rdata_d  = rHs ? bus.rdata : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q    <= '0;
            araddr_q <= 32'h0;
            arsize_q <= 3'b010;
            dataOk_q <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            cnt_q    <= cnt_d;
            araddr_q <= araddr_d;
            arsize_q <= arsize_d;
            dataOk_q <= dataOk_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.arid              = AXI_ID;
    assign bus.araddr            = araddr_q;
    assign bus.arlen             = 8'd0;
    assign bus.arsize            = arsize_q;
    assign bus.arburst           = 2'b01;
    assign bus.inst_sram_data_ok = dataOk_q;
    assign bus.inst_sram_rdata   = rdata_q;

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge: expected read data is queued as R beats are
// issued, and a negedge monitor pops and compares on every data_ok pulse.
module tb_inst_sram_axi_bridge;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    bit   monitorOn;
    logic [31:0] expQ[$];

    inst_sram_axi_bridge_if bus ();

    inst_sram_axi_bridge #(
        .MAX_OUTSTANDING(2),
        .AXI_ID(4'd0)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive just after posedge, return at negedge for sampling.
    task automatic applyStimulus(input logic en, input logic wr, input logic [31:0] addr,
                                 input logic arready, input logic rvalid, input logic [3:0] rid,
                                 input logic [31:0] rdata);
        @(posedge clk);
        #1;
        bus.inst_sram_en   = en;
        bus.inst_sram_wr   = wr;
        bus.inst_sram_addr = addr;
        bus.arready        = arready;
        bus.rvalid         = rvalid;
        bus.rid            = rid;
        bus.rdata          = rdata;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0, 32'h0);
    endtask

    always @(negedge clk) begin
        if (monitorOn && bus.inst_sram_data_ok !== 1'b0) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedDataOk actual=%h required=no pulse at %0t",
                         bus.inst_sram_rdata, $time);
            end else begin
                checkOutput("dataOkRdata", bus.inst_sram_rdata, expQ.pop_front());
            end
        end
    end

    initial begin
        logic [5:0]  expOk;
        logic [31:0] reqAddr[3];
        int          idx;

        checks    = 0;
        errors    = 0;
        monitorOn = 1'b0;
        resetn    = 1'b0;
        bus.inst_sram_en   = 1'b0;
        bus.inst_sram_wr   = 1'b0;
        bus.inst_sram_size = 2'b10;
        bus.inst_sram_addr = 32'h0;
        bus.arready        = 1'b0;
        bus.rvalid         = 1'b0;
        bus.rid            = 4'd0;
        bus.rdata          = 32'h0;
        bus.rresp          = 2'b00;
        bus.rlast          = 1'b1;

        idleCycle();
        idleCycle();
        resetn    = 1'b1;
        monitorOn = 1'b1;
        checkOutput("resetArvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("resetDataOk", 32'(bus.inst_sram_data_ok), 32'd0);
        checkOutput("resetRdata", bus.inst_sram_rdata, 32'h0);
        checkOutput("resetAraddr", bus.araddr, 32'h0);
        checkOutput("resetArsize", 32'(bus.arsize), 32'd2);
        checkOutput("resetCnt", 32'(dut.cnt_q), 32'd0);
        checkOutput("resetRready", 32'(bus.rready), 32'd0);

        $display("[TB] single fetch round trip");
        applyStimulus(1'b1, 1'b0, 32'h1c000000, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("t1AddrOk", 32'(bus.inst_sram_addr_ok), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("t1Arvalid", 32'(bus.arvalid), 32'd1);
        checkOutput("t1Araddr", bus.araddr, 32'h1c000000);
        checkOutput("t1Arsize", 32'(bus.arsize), 32'd2);
        checkOutput("t1Arlen", 32'(bus.arlen), 32'd0);
        checkOutput("t1Arburst", 32'(bus.arburst), 32'd1);
        checkOutput("t1Arid", 32'(bus.arid), 32'd0);
        expQ.push_back(32'h02800c0c);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'h02800c0c);
        checkOutput("t1Rready", 32'(bus.rready), 32'd1);
        checkOutput("t1ArvalidCleared", 32'(bus.arvalid), 32'd0);
        idleCycle();
        checkOutput("t1CntZero", 32'(dut.cnt_q), 32'd0);

        $display("[TB] outstanding limit");
        reqAddr[0] = 32'h1c000000;
        reqAddr[1] = 32'h1c000004;
        reqAddr[2] = 32'h1c000008;
        expOk = 6'b000101;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, reqAddr[idx], 1'b1, 1'b0, 4'd0, 32'h0);
            checkOutput("t2AddrOk", 32'(bus.inst_sram_addr_ok), 32'(expOk[c]));
            if (c == 1) checkOutput("t2AraddrA", bus.araddr, 32'h1c000000);
            if (c == 3) checkOutput("t2AraddrB", bus.araddr, 32'h1c000004);
            if (expOk[c]) idx++;
        end
        checkOutput("t2CntFull", 32'(dut.cnt_q), 32'd2);
        expQ.push_back(32'ha0a0a0a0);
        applyStimulus(1'b1, 1'b0, 32'h1c000008, 1'b1, 1'b1, 4'd0, 32'ha0a0a0a0);
        checkOutput("t2AddrOkBlocked", 32'(bus.inst_sram_addr_ok), 32'd0);
        checkOutput("t2Rready", 32'(bus.rready), 32'd1);
        applyStimulus(1'b1, 1'b0, 32'h1c000008, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("t2AddrOkFreed", 32'(bus.inst_sram_addr_ok), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("t2AraddrC", bus.araddr, 32'h1c000008);
        checkOutput("t2CntAfterC", 32'(dut.cnt_q), 32'd2);

        $display("[TB] back-to-back responses");
        expQ.push_back(32'h11111111);
        applyStimulus(1'b1, 1'b0, 32'h1c00000c, 1'b0, 1'b1, 4'd0, 32'h11111111);
        checkOutput("t4AddrOkFull", 32'(bus.inst_sram_addr_ok), 32'd0);
        expQ.push_back(32'h22222222);
        applyStimulus(1'b1, 1'b0, 32'h1c00000c, 1'b0, 1'b1, 4'd0, 32'h22222222);
        checkOutput("t4AddrOkBoth", 32'(bus.inst_sram_addr_ok), 32'd1);
        expQ.push_back(32'h33333333);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'd0, 32'h33333333);
        checkOutput("t4CntSame", 32'(dut.cnt_q), 32'd1);
        checkOutput("t4Rready", 32'(bus.rready), 32'd1);
        idleCycle();
        checkOutput("t4CntZero", 32'(dut.cnt_q), 32'd0);
        checkOutput("t4RreadyLow", 32'(bus.rready), 32'd0);

        $display("[TB] arready stall");
        applyStimulus(1'b1, 1'b0, 32'h1c000100, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("t3AddrOk", 32'(bus.inst_sram_addr_ok), 32'd1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h1c000200, 1'b0, 1'b0, 4'd0, 32'h0);
            checkOutput("t3Arvalid", 32'(bus.arvalid), 32'd1);
            checkOutput("t3AraddrStable", bus.araddr, 32'h1c000100);
            checkOutput("t3AddrOkLow", 32'(bus.inst_sram_addr_ok), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("t3ArvalidHs", 32'(bus.arvalid), 32'd1);
        idleCycle();
        checkOutput("t3ArvalidDone", 32'(bus.arvalid), 32'd0);
        checkOutput("t3Cnt", 32'(dut.cnt_q), 32'd1);

        $display("[TB] rid and empty-counter filtering");
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd5, 32'hdeadbeef);
            checkOutput("t5RreadyBadId", 32'(bus.rready), 32'd0);
        end
        expQ.push_back(32'h55555555);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'h55555555);
        checkOutput("t5RreadyGoodId", 32'(bus.rready), 32'd1);
        idleCycle();
        checkOutput("t5CntZero", 32'(dut.cnt_q), 32'd0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 4'd0, 32'hcafef00d);
            checkOutput("t5RreadyCntZero", 32'(bus.rready), 32'd0);
        end
        idleCycle();
        checkOutput("t5RdataHeld", bus.inst_sram_rdata, 32'h55555555);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 32'h1c000300, 1'b1, 1'b0, 4'd0, 32'h0);
        checkOutput("t6AddrOkA", 32'(bus.inst_sram_addr_ok), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'd0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h1c000304, 1'b0, 1'b0, 4'd0, 32'h0);
        checkOutput("t6AddrOkB", 32'(bus.inst_sram_addr_ok), 32'd1);
        idleCycle();
        checkOutput("t6PreCnt", 32'(dut.cnt_q), 32'd2);
        checkOutput("t6PreArvalid", 32'(bus.arvalid), 32'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("t6Arvalid", 32'(bus.arvalid), 32'd0);
        checkOutput("t6Cnt", 32'(dut.cnt_q), 32'd0);
        checkOutput("t6DataOk", 32'(bus.inst_sram_data_ok), 32'd0);
        checkOutput("t6Araddr", bus.araddr, 32'h0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 1'b1, 32'h1c000400, 1'b1, 1'b0, 4'd0, 32'h0);
            checkOutput("t6AddrOkWr", 32'(bus.inst_sram_addr_ok), 32'd0);
            checkOutput("t6ArvalidWr", 32'(bus.arvalid), 32'd0);
        end

        idleCycle();
        idleCycle();
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
